dm_block_copy: RTL and testbench
================================

// Module: dm_block_copy
// PURPOSE
//  Initiator for the data-memory (DM) port: on start, copies Length 32-bit words from
//  SrcAddr.. to DstAddr.. inside DM using the DM MemRead/MemWrite/Address/WriteData/ReadData
//  interface. It sits beside the datapath as a DM bus master. Status is signalled by busy/done.
// PARAMETERS
//  ADDR_W  8   DM word-address width; DM depth = 2**ADDR_W words
//  DATA_W  32  DM data width
// PORTS
//  clock      in   1       system clock; all state updates on rising edge
//  reset      in   1       synchronous, active-high reset
//  start      in   1       request copy; sampled only in IDLE
//  SrcAddr    in   ADDR_W  first source word address (captured on accepted start)
//  DstAddr    in   ADDR_W  first destination word address (captured on accepted start)
//  Length     in   ADDR_W  word count, 0..255 (captured on accepted start)
//  MemRead    out  1       DM read enable
//  MemWrite   out  1       DM write enable
//  Address    out  ADDR_W  DM word address
//  WriteData  out  DATA_W  DM write data
//  ReadData   in   DATA_W  DM read data; combinational from Address while MemRead=1
//  busy       out  1       high from cycle after accepted start until done cycle inclusive
//  done       out  1       one-cycle pulse when copy completes
// BEHAVIOUR
//  - Clock is one domain; reset is synchronous, active-high. On reset: state=IDLE,
//    MemRead=MemWrite=0, Address=0, WriteData=0, busy=0, done=0, internal regs=0.
//  - DM contract: read is combinational (ReadData valid same cycle as MemRead+Address);
//    write commits at rising clock edge while MemWrite=1.
//  - FSM states: IDLE, READ, WRITE, DONE. All DM outputs decoded from registered state/regs.
//    IDLE : outputs 0. start=1 -> capture Src/Dst/Length, idx=0;
//           Length==0 -> DONE, else -> READ.
//    READ : MemRead=1, Address=src+idx; at edge data_reg<=ReadData; -> WRITE.
//    WRITE: MemWrite=1, Address=dst+idx, WriteData=data_reg; at edge idx<=idx+1;
//           idx==len-1 -> DONE else -> READ.
//    DONE : done=1, busy=1, DM outputs 0; -> IDLE unconditionally.
//  - MemRead and MemWrite never high in the same cycle.
//  - Throughput 2 cycles/word; start-accept to done pulse = 2*Length+1 cycles (Length=0: 1).
//  - Address arithmetic modulo 2**ADDR_W: src+idx, dst+idx wrap 255->0 silently.
//  - Copy order strictly ascending idx; overlapping ranges are copied word-by-word in that
//    order (dst=src+1 replicates word[src] forward). No overlap detection.
//  - start while not IDLE ignored; Src/Dst/Length changes after acceptance ignored.
//  - start in DONE cycle ignored; a new start is accepted the following (IDLE) cycle.
//  - reset asserted mid-copy: next cycle IDLE, all outputs 0; writes already committed stay;
//    no done pulse for the aborted copy.
// STRUCTURE
//  - Shared header dm_defs.vh: ADDR_W/DATA_W defaults, FSM state encodings
//    (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3).
//  - Single module; no sub-module is natural (idx counter + FSM are ~20 lines).
//  - Bench instantiates dm_block_copy driving the existing DM model.
// TESTING
//  1 Reset: reset=1 for 2 cycles -> all outputs 0, busy=0; release, start=0 -> stays IDLE.
//  2 Copy: DM[20]=32'h55555555,DM[21]=32'haaaaaaaa; Src=20,Dst=40,Len=2 -> DM[40]=h55555555,
//    DM[41]=haaaaaaaa, done pulses exactly 5 cycles after start accept, DM[20..21] unchanged.
//  3 Length=0: Src=20,Dst=40,Len=0 -> no MemRead/MemWrite cycle, done 1 cycle after accept.
//  4 Wrap: DM[254]=h11111111,DM[255]=h22222222,DM[0]=h33333333; Src=254,Dst=100,Len=3 ->
//    DM[100..102]=h11111111,h22222222,h33333333.
//  5 Overlap+ignored start: DM[20]=hcccccccc; Src=20,Dst=21,Len=3, pulse start mid-copy ->
//    DM[21..23]=hcccccccc, single done pulse, second start has no effect.
//  6 Abort: Len=10 from Src=0,Dst=128; assert reset after 7 cycles -> next cycle IDLE, outputs 0,
//    DM[128..130] copied, DM[131..137] untouched, no done pulse.

Source files
------------

// File: rtl/dm_block_copy_pkg.sv
// dm_block_copy_pkg: shared widths and FSM encoding for the DM block copier.
// Imported by dm_block_copy; no ports.
package dm_block_copy_pkg;

  localparam int unsigned DM_ADDR_W = 8;
  localparam int unsigned DM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } dm_state_e;

endpackage

// File: rtl/dm_block_copy.sv
// dm_block_copy: DM bus master copying Length words SrcAddr.. -> DstAddr..
// Ports: clock/reset, start+SrcAddr/DstAddr/Length in; DM MemRead/MemWrite/
//   Address/WriteData out, ReadData in; busy/done status out.
module dm_block_copy
  import dm_block_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DM_ADDR_W,
  parameter int unsigned DATA_W = DM_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Length,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData,
  output logic              busy,
  output logic              done
);

  dm_state_e         state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              done_q;

  // DM outputs are registered one state ahead, so each is valid for
  // exactly the cycle its state is active. wdata_q doubles as data_reg.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          wdata_q <= '0;
          if (start) begin
            src_q  <= SrcAddr;
            dst_q  <= DstAddr;
            len_q  <= Length;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (Length == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              rd_q    <= 1'b1;
              addr_q  <= SrcAddr;
            end
          end
        end
        S_READ: begin
          state_q <= S_WRITE;
          wr_q    <= 1'b1;
          addr_q  <= dst_q + idx_q;
          wdata_q <= ReadData;
        end
        S_WRITE: begin
          wdata_q <= '0;
          idx_q   <= idx_q + ADDR_W'(1);
          if (idx_q == len_q - ADDR_W'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_READ;
            rd_q    <= 1'b1;
            addr_q  <= src_q + idx_q + ADDR_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  assign MemRead   = rd_q;
  assign MemWrite  = wr_q;
  assign Address   = addr_q;
  assign WriteData = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dm_block_copy.sv
// tb_dm_block_copy: directed bench for dm_block_copy with a DM model.
// Each scenario task drives stimulus and checks its own results.
module tb_dm_block_copy;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  SrcAddr;
  logic [7:0]  DstAddr;
  logic [7:0]  Length;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:255];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  int tests;
  int fails;

  dm_block_copy dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .SrcAddr  (SrcAddr),
    .DstAddr  (DstAddr),
    .Length   (Length),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ReadData = MemRead ? mem[Address] : 32'h0;

  always @(posedge clock) begin
    if (MemWrite) mem[Address] <= WriteData;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clock);
    ld_en = 1'b1;
    ld_addr = a[7:0];
    ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Stimulus only: launches a copy and gathers per-cycle statistics.
  task automatic run_copy(
    input  logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
    input  int mid_start, input int max_c,
    output int done_cyc, output int n_done, output int rd_cnt,
    output int wr_cnt, output int both_cnt, output int busy_low
  );
    done_cyc = -1; n_done = 0; rd_cnt = 0;
    wr_cnt = 0; both_cnt = 0; busy_low = 0;
    @(negedge clock);
    SrcAddr = s; DstAddr = d; Length = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      if (c > 1) @(negedge clock);
      if (MemRead) rd_cnt++;
      if (MemWrite) wr_cnt++;
      if (MemRead && MemWrite) both_cnt++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!busy && done_cyc < 0) busy_low++;
      if (c == mid_start) begin
        start = 1'b1; SrcAddr = ~s; Length = 8'd200;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({MemRead, MemWrite, busy, done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl got %b want 0000",
               {MemRead, MemWrite, busy, done});
    end
    tests++;
    if ({Address, WriteData} !== 40'h0) begin
      fails++;
      $display("FAIL reset_bus got %h/%h want 0/0", Address, WriteData);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if ({MemRead, MemWrite, busy, done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle got %b want 0000",
               {MemRead, MemWrite, busy, done});
    end
  endtask

  task automatic test_copy();
    int dc, nd, rc, wc, bc, bl;
    poke(20, 32'h55555555); poke(21, 32'haaaaaaaa);
    poke(40, 32'h0); poke(41, 32'h0);
    run_copy(8'd20, 8'd40, 8'd2, 0, 10, dc, nd, rc, wc, bc, bl);
    tests++;
    if (dc !== 5) begin
      fails++; $display("FAIL copy_done_cyc got %0d want 5", dc);
    end
    tests++;
    if ({nd, rc, wc, bc, bl} !== {32'd1, 32'd2, 32'd2, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL copy_counts got d%0d r%0d w%0d both%0d bl%0d want 1 2 2 0 0",
               nd, rc, wc, bc, bl);
    end
    tests++;
    if (mem[40] !== 32'h55555555 || mem[41] !== 32'haaaaaaaa) begin
      fails++;
      $display("FAIL copy_dst got %h %h want 55555555 aaaaaaaa",
               mem[40], mem[41]);
    end
    tests++;
    if (mem[20] !== 32'h55555555 || mem[21] !== 32'haaaaaaaa) begin
      fails++;
      $display("FAIL copy_src got %h %h want 55555555 aaaaaaaa",
               mem[20], mem[21]);
    end
  endtask

  task automatic test_len_zero();
    int dc, nd, rc, wc, bc, bl;
    run_copy(8'd20, 8'd40, 8'd0, 0, 5, dc, nd, rc, wc, bc, bl);
    tests++;
    if (dc !== 1 || nd !== 1) begin
      fails++;
      $display("FAIL len0_done got cyc%0d n%0d want cyc1 n1", dc, nd);
    end
    tests++;
    if (rc !== 0 || wc !== 0) begin
      fails++;
      $display("FAIL len0_access got r%0d w%0d want 0 0", rc, wc);
    end
  endtask

  task automatic test_wrap();
    int dc, nd, rc, wc, bc, bl;
    poke(254, 32'h11111111); poke(255, 32'h22222222);
    poke(0, 32'h33333333);
    poke(100, 32'h0); poke(101, 32'h0); poke(102, 32'h0);
    run_copy(8'd254, 8'd100, 8'd3, 0, 10, dc, nd, rc, wc, bc, bl);
    tests++;
    if (mem[100] !== 32'h11111111 || mem[101] !== 32'h22222222 ||
        mem[102] !== 32'h33333333) begin
      fails++;
      $display("FAIL wrap_dst got %h %h %h want 11111111 22222222 33333333",
               mem[100], mem[101], mem[102]);
    end
    tests++;
    if (dc !== 7) begin
      fails++; $display("FAIL wrap_done_cyc got %0d want 7", dc);
    end
  endtask

  task automatic test_overlap();
    int dc, nd, rc, wc, bc, bl;
    poke(20, 32'hcccccccc); poke(21, 32'h0);
    poke(22, 32'h0); poke(23, 32'h0); poke(24, 32'h00000024);
    run_copy(8'd20, 8'd21, 8'd3, 3, 14, dc, nd, rc, wc, bc, bl);
    tests++;
    if (mem[21] !== 32'hcccccccc || mem[22] !== 32'hcccccccc ||
        mem[23] !== 32'hcccccccc) begin
      fails++;
      $display("FAIL overlap_dst got %h %h %h want cccccccc x3",
               mem[21], mem[22], mem[23]);
    end
    tests++;
    if (mem[24] !== 32'h00000024) begin
      fails++;
      $display("FAIL overlap_past_end got %h want 00000024", mem[24]);
    end
    tests++;
    if (nd !== 1 || dc !== 7 || rc !== 3 || wc !== 3 || bc !== 0) begin
      fails++;
      $display("FAIL overlap_counts got d%0d cyc%0d r%0d w%0d b%0d want 1 7 3 3 0",
               nd, dc, rc, wc, bc);
    end
  endtask

  task automatic test_back_to_back();
    poke(50, 32'h5a5a5a5a); poke(60, 32'h0);
    @(negedge clock);
    SrcAddr = 8'd50; DstAddr = 8'd60; Length = 8'd1; start = 1'b1;
    @(negedge clock);
    tests++;
    if (MemRead !== 1'b1 || Address !== 8'd50) begin
      fails++;
      $display("FAIL b2b_read got rd%b a%0d want rd1 a50", MemRead, Address);
    end
    @(negedge clock);
    tests++;
    if (MemWrite !== 1'b1 || Address !== 8'd60 ||
        WriteData !== 32'h5a5a5a5a) begin
      fails++;
      $display("FAIL b2b_write got wr%b a%0d d%h want wr1 a60 d5a5a5a5a",
               MemWrite, Address, WriteData);
    end
    @(negedge clock);
    tests++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done got done%b busy%b want 1 1", done, busy);
    end
    @(negedge clock);
    tests++;
    if (busy !== 1'b0 || MemRead !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle got busy%b rd%b done%b want 0 0 0",
               busy, MemRead, done);
    end
    @(negedge clock);
    start = 1'b0;
    tests++;
    if (MemRead !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart got rd%b busy%b want 1 1", MemRead, busy);
    end
    repeat (4) @(negedge clock);
    tests++;
    if (busy !== 1'b0 || mem[60] !== 32'h5a5a5a5a) begin
      fails++;
      $display("FAIL b2b_end got busy%b m60 %h want 0 5a5a5a5a",
               busy, mem[60]);
    end
  endtask

  task automatic test_abort();
    int dn;
    int bad;
    dn = 0; bad = 0;
    for (int i = 0; i < 10; i++) poke(i, 32'h10000000 + i);
    for (int i = 128; i < 138; i++) poke(i, 32'hdeadbeef);
    @(negedge clock);
    SrcAddr = 8'd0; DstAddr = 8'd128; Length = 8'd10; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clock);
      if (done) dn++;
    end
    reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({MemRead, MemWrite, busy, done} !== 4'b0 ||
        {Address, WriteData} !== 40'h0) begin
      fails++;
      $display("FAIL abort_outputs got %b %h %h want 0000 00 00000000",
               {MemRead, MemWrite, busy, done}, Address, WriteData);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) dn++;
    end
    tests++;
    if (dn !== 0) begin
      fails++; $display("FAIL abort_no_done got %0d pulses want 0", dn);
    end
    for (int i = 0; i < 3; i++)
      if (mem[128 + i] !== 32'h10000000 + i) bad++;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL abort_copied got %0d wrong want 0", bad);
    end
    bad = 0;
    for (int i = 131; i < 138; i++)
      if (mem[i] !== 32'hdeadbeef) bad++;
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL abort_untouched got %0d changed want 0", bad);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; start = 1'b0;
    SrcAddr = '0; DstAddr = '0; Length = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    test_reset();
    test_copy();
    test_len_zero();
    test_wrap();
    test_overlap();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
